// File: rtl/module_mem_responder.sv
// ============================================================================
// module_mem_responder: wait-state RAM + LED/switch MMIO responder
// Revision: 1.0
// ============================================================================
`default_nettype none

module module_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] LED_ADDR    = 32'h0000_2000,
    parameter logic [31:0] SW_ADDR     = 32'h0000_2004
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [15:0] sw_i,
    output logic        ready_o,
    output logic        err_o,
    output logic [31:0] rdata_o,
    output logic        busy_o,
    output logic [15:0] leds_o
);

    localparam int unsigned AW        = $clog2(DEPTH_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);
    localparam logic [3:0]  CNT_INIT  = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t        state_q;
    logic [3:0]    cnt_q;
    logic          we_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic          ready_q;
    logic          err_q;
    logic [31:0]   rdata_q;
    logic [15:0]   leds_q;
    logic [15:0]   sw_meta_q;
    logic [15:0]   sw_sync_q;
    logic [31:0]   mem_q [DEPTH_WORDS];

    logic          acc_we;
    logic [31:0]   acc_addr;
    logic [31:0]   acc_wdata;
    logic          enter_resp;
    logic          misaligned;
    logic          hit_ram;
    logic          hit_led;
    logic          hit_sw;
    logic [AW-1:0] ram_idx;
    logic          ram_we;
    logic          led_we;
    logic [31:0]   rdata_d;
    logic          err_d;

    // With zero wait states the access completes on the accept edge, so the
    // live inputs stand in for the not-yet-captured request.
    always_comb begin
        acc_we     = (state_q == S_IDLE) ? we_i    : we_q;
        acc_addr   = (state_q == S_IDLE) ? addr_i  : addr_q;
        acc_wdata  = (state_q == S_IDLE) ? wdata_i : wdata_q;
        enter_resp = ((state_q == S_IDLE) && req_i && (WAIT_CYCLES == 0)) ||
                     ((state_q == S_WAIT) && (cnt_q == 4'd0));
        misaligned = (acc_addr[1:0] != 2'b00);
        hit_ram    = !misaligned && (acc_addr < RAM_BYTES);
        hit_led    = !misaligned && (acc_addr == LED_ADDR);
        hit_sw     = !misaligned && (acc_addr == SW_ADDR);
        ram_idx    = acc_addr[AW+1:2];
        ram_we     = rst_i && enter_resp && acc_we && hit_ram;
        led_we     = enter_resp && acc_we && !hit_ram && hit_led;
        rdata_d    = 32'h0;
        err_d      = 1'b0;
        if (!(hit_ram || hit_led || hit_sw)) begin
            err_d = 1'b1;
        end else if (!acc_we) begin
            if (hit_ram) begin
                rdata_d = mem_q[ram_idx];
            end else if (hit_led) begin
                rdata_d = {16'h0, leds_q};
            end else begin
                rdata_d = {16'h0, sw_sync_q};
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (ram_we) begin
            mem_q[ram_idx] <= acc_wdata;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            we_q      <= 1'b0;
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= 32'h0;
            leds_q    <= 16'h0;
            sw_meta_q <= 16'h0;
            sw_sync_q <= 16'h0;
        end else begin
            sw_meta_q <= sw_i;
            sw_sync_q <= sw_meta_q;
            if (led_we) begin
                leds_q <= acc_wdata[15:0];
            end
            case (state_q)
                S_IDLE: begin
                    if (req_i) begin
                        we_q    <= we_i;
                        addr_q  <= addr_i;
                        wdata_q <= wdata_i;
                        cnt_q   <= CNT_INIT;
                        state_q <= (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b0;
                    err_q   <= 1'b0;
                    rdata_q <= 32'h0;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
            if (enter_resp) begin
                ready_q <= 1'b1;
                err_q   <= err_d;
                rdata_q <= rdata_d;
            end
        end
    end

    assign ready_o = ready_q;
    assign err_o   = err_q;
    assign rdata_o = rdata_q;
    assign busy_o  = (state_q != S_IDLE);
    assign leds_o  = leds_q;

endmodule

`default_nettype wire

// File: tb/tb_module_mem_responder.sv
// Bench for module_mem_responder: transaction-level model plus directed vectors.
`default_nettype none

module tb_module_mem_responder;

    localparam int          W    = 2;
    localparam logic [31:0] LEDA = 32'h0000_2000;
    localparam logic [31:0] SWA  = 32'h0000_2004;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [15:0] sw = 16'h0;
    logic        ready_o, err_o, busy_o;
    logic [31:0] rdata_o;
    logic [15:0] leds_o;

    int checks = 0;
    int failures = 0;

    module_mem_responder #(
        .DEPTH_WORDS(256), .WAIT_CYCLES(W), .LED_ADDR(LEDA), .SW_ADDR(SWA)
    ) dut (
        .clk_i(clk), .rst_i(rst_n), .req_i(req), .we_i(we), .addr_i(addr),
        .wdata_i(wdata), .sw_i(sw), .ready_o(ready_o), .err_o(err_o),
        .rdata_o(rdata_o), .busy_o(busy_o), .leds_o(leds_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h at t=%0t", name, got, exp, $time);
        end
    endtask

    // Transaction-level model: a request accepted at edge c completes at edge c+W,
    // its response is visible for one cycle, then the responder is free again.
    bit          m_inflight = 0;
    bit          m_ready = 0;
    bit          m_err = 0;
    logic [31:0] m_rdata = 0;
    logic [15:0] m_leds = 0;
    logic [15:0] m_sw1 = 0, m_sw2 = 0;
    int          m_cyc = 0, m_resp_edge = 0;
    bit          m_we = 0;
    logic [31:0] m_addr = 0, m_wdata = 0;
    logic [31:0] m_mem [int];

    function automatic void mdl_access();
        bit in_ram = (m_addr < 32'd1024);
        m_ready = 1;
        m_err   = 0;
        m_rdata = 0;
        if ((m_addr % 4) != 0 || !(in_ram || m_addr == LEDA || m_addr == SWA)) begin
            m_err = 1;
        end else if (m_we) begin
            if (in_ram) m_mem[int'(m_addr / 4)] = m_wdata;
            else if (m_addr == LEDA) m_leds = m_wdata[15:0];
        end else begin
            if (in_ram) m_rdata = m_mem.exists(int'(m_addr / 4)) ? m_mem[int'(m_addr / 4)] : 'x;
            else if (m_addr == LEDA) m_rdata = {16'h0, m_leds};
            else m_rdata = {16'h0, m_sw2};
        end
    endfunction

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_inflight = 0; m_ready = 0; m_err = 0; m_rdata = 0;
            m_leds = 0; m_sw1 = 0; m_sw2 = 0;
        end else begin
            m_cyc++;
            if (m_ready) begin
                m_ready = 0; m_err = 0; m_rdata = 0; m_inflight = 0;
            end else if (m_inflight) begin
                if (m_cyc == m_resp_edge) mdl_access();
            end else if (req) begin
                m_we = we; m_addr = addr; m_wdata = wdata;
                m_inflight = 1;
                m_resp_edge = m_cyc + W;
                if (W == 0) mdl_access();
            end
            m_sw2 = m_sw1;
            m_sw1 = sw;
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            check("cmp_ready", 32'(ready_o), 32'(m_ready));
            check("cmp_busy",  32'(busy_o),  32'(m_inflight));
            check("cmp_err",   32'(err_o),   32'(m_err));
            check("cmp_rdata", rdata_o,      m_rdata);
            check("cmp_leds",  32'(leds_o),  32'(m_leds));
        end
    end

    task automatic do_req(input bit w, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output logic e);
        int lat = -1;
        @(negedge clk);
        #1 req = 1; we = w; addr = a; wdata = d;
        @(posedge clk);
        #1 req = 0; we = ~w; addr = $urandom; wdata = $urandom;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (ready_o) begin
                lat = k;
                break;
            end
        end
        check("latency", 32'(lat), 32'(W));
        rd = rdata_o;
        e  = err_o;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd;
        logic        e;
        int          n;

        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(ready_o), 32'h0);
        check("rst_busy",  32'(busy_o),  32'h0);
        check("rst_err",   32'(err_o),   32'h0);
        check("rst_rdata", rdata_o,      32'h0);
        check("rst_leds",  32'(leds_o),  32'h0);
        @(negedge clk);
        #2 rst_n = 1;

        do_req(1, 32'h10, 32'hDEAD_BEEF, rd, e);
        check("wr10_rdata", rd, 32'h0);
        check("wr10_err", 32'(e), 32'h0);
        do_req(0, 32'h10, 32'h0, rd, e);
        check("rd10_rdata", rd, 32'hDEAD_BEEF);
        check("rd10_err", 32'(e), 32'h0);

        do_req(1, 32'h3FC, 32'h1234_5678, rd, e);
        do_req(0, 32'h3FC, 32'h0, rd, e);
        check("rd3fc_rdata", rd, 32'h1234_5678);
        do_req(0, 32'h400, 32'h0, rd, e);
        check("rd400_err", 32'(e), 32'h1);

        do_req(1, LEDA, 32'h0000_A5A5, rd, e);
        check("ledwr_leds", 32'(leds_o), 32'h0000_A5A5);
        check("ledwr_rdata", rd, 32'h0);
        do_req(0, LEDA, 32'h0, rd, e);
        check("ledrd_rdata", rd, 32'h0000_A5A5);

        sw = 16'h1234;
        repeat (4) @(negedge clk);
        do_req(0, SWA, 32'h0, rd, e);
        check("swrd_rdata", rd, 32'h0000_1234);
        check("swrd_err", 32'(e), 32'h0);
        do_req(1, SWA, 32'hFFFF_FFFF, rd, e);
        check("swwr_err", 32'(e), 32'h0);
        check("swwr_rdata", rd, 32'h0);
        do_req(0, SWA, 32'h0, rd, e);
        check("swrd2_rdata", rd, 32'h0000_1234);

        do_req(0, 32'h402, 32'h0, rd, e);
        check("mis_err", 32'(e), 32'h1);
        check("mis_rdata", rd, 32'h0);
        do_req(0, 32'h3000, 32'h0, rd, e);
        check("unm_err", 32'(e), 32'h1);
        check("unm_rdata", rd, 32'h0);
        do_req(1, 32'h12, 32'h5555_5555, rd, e);
        check("miswr_err", 32'(e), 32'h1);
        do_req(1, 32'h3000, 32'h0000_0001, rd, e);
        check("unmwr_err", 32'(e), 32'h1);
        check("unmwr_leds", 32'(leds_o), 32'h0000_A5A5);
        do_req(0, 32'h10, 32'h0, rd, e);
        check("rd10_after_err", rd, 32'hDEAD_BEEF);

        n = 0;
        @(negedge clk);
        #1 req = 1; we = 0; addr = 32'h10;
        for (int i = 0; i < 24; i++) begin
            @(posedge clk);
            if (i == 15) begin
                #1 req = 0;
            end
            @(negedge clk);
            if (ready_o) n++;
        end
        check("hold_req_pulses", 32'(n), 32'd4);

        @(negedge clk);
        #1 req = 1; we = 1; addr = LEDA; wdata = 32'h1;
        @(posedge clk);
        #1 req = 0;
        @(negedge clk);
        #1 rst_n = 0;
        #1;
        check("midrst_busy",  32'(busy_o),  32'h0);
        check("midrst_ready", 32'(ready_o), 32'h0);
        check("midrst_leds",  32'(leds_o),  32'h0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1;
        repeat (6) @(negedge clk);
        check("postrst_leds", 32'(leds_o), 32'h0);
        do_req(0, LEDA, 32'h0, rd, e);
        check("postrst_ledrd", rd, 32'h0);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
